// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the accumulator CPU.
package cpu_pkg;

    localparam int WORD_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W_DEF  = 16;

    // Sequencer phases, one-hot so each strobe is a bare flop output
    typedef enum logic [3:0] {
        ST_HALT = 4'b0001,
        ST_F    = 4'b0010,
        ST_E1   = 4'b0100,
        ST_E2   = 4'b1000
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JMI = 4'h5;
    localparam logic [3:0] OP_JEQ = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_AND = 4'h9;
    localparam logic [3:0] OP_OR  = 4'hA;
    localparam logic [3:0] OP_ASR = 4'hB;

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: phase strobes, instruction register and flags from the
// sequencer to the decoder, plus the decoder's request for a second execute cycle.
interface cpu_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              FETCH;
    logic              EXEC1;
    logic              EXEC2;
    logic [3:0]        IR;
    logic [ADDR_W-1:0] OPERAND;
    logic              EQ;
    logic              MI;
    logic              EXTRA;

    modport master (
        output FETCH, EXEC1, EXEC2, IR, OPERAND, EQ, MI,
        input  EXTRA
    );

    modport slave (
        input  FETCH, EXEC1, EXEC2, IR, OPERAND, EQ, MI,
        output EXTRA
    );
endinterface

// File: rtl/cpu_sequencer_sync_edge.sv
// sync_edge: two-flop synchroniser for a board switch with a registered
// rising-edge pulse that lines up with the synchronised level.
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);
    logic meta;

    // Rise is taken from meta/level so it is high in the same cycle the level first reads 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            meta  <= din;
            level <= meta;
            rise  <= meta & ~level;
        end
    end
endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: phase timing generator, instruction register and
// run/step/halt control for the accumulator CPU.
//
//   state  | meaning
//   HALT   | idle, waiting for RUN or STEP
//   F      | fetch strobe, IR/OPERAND latched from MEM_Q at the closing edge
//   E1     | first execute cycle, EXTRA sampled here
//   E2     | second execute cycle for instructions that asked for it
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int         WORD_W = WORD_W_DEF,
    parameter int         ADDR_W = ADDR_W_DEF,
    parameter int         DATA_W = DATA_W_DEF,
    parameter int         CNT_W  = CNT_W_DEF,
    parameter logic [3:0] STP_OP = OP_STP
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              RUN,
    input  logic              STEP,
    input  logic [WORD_W-1:0] MEM_Q,
    input  logic [DATA_W-1:0] ACC,
    output logic              HALTED,
    output logic              STOPPED,
    output logic [CNT_W-1:0]  INSTR_CNT,
    cpu_sequencer_if.master   dec
);
    localparam logic [3:0] S_HALT = ST_HALT;
    localparam logic [3:0] S_F    = ST_F;
    localparam logic [3:0] S_E1   = ST_E1;
    localparam logic [3:0] S_E2   = ST_E2;

    logic [3:0]        state;
    logic [3:0]        end_state;
    logic              step_mode;
    logic              instr_end;
    logic [3:0]        ir;
    logic [ADDR_W-1:0] operand;
    logic              run_lvl;
    logic              run_rise;
    logic              step_rise;
    logic              unused_step_level;

    sync_edge u_run_sync (
        .clk   (CLK),
        .rst_n (RESET_N),
        .din   (RUN),
        .level (run_lvl),
        .rise  (run_rise)
    );

    sync_edge u_step_sync (
        .clk   (CLK),
        .rst_n (RESET_N),
        .din   (STEP),
        .level (unused_step_level),
        .rise  (step_rise)
    );

    // MEM_Q bits between the operand field and the opcode carry nothing for the sequencer
    generate
        if (ADDR_W < WORD_W - 4) begin : g_mem_gap
            logic unused_mem_gap;
            assign unused_mem_gap = ^MEM_Q[WORD_W-5:ADDR_W];
        end
    endgenerate

    assign instr_end = (state == S_E2) || ((state == S_E1) && !dec.EXTRA);

    // Where an instruction goes once it ends: STP and single-step both park in HALT
    always_comb begin
        end_state = S_F;
        if ((ir == STP_OP) || step_mode || !run_lvl) begin
            end_state = S_HALT;
        end
    end

    // Phase sequencing, start/stop control and instruction latch
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= S_HALT;
            step_mode <= 1'b0;
            STOPPED   <= 1'b0;
            ir        <= '0;
            operand   <= '0;
        end else begin
            case (state)
                S_HALT: begin
                    // A fresh RUN edge overrides a sticky STP; a plain RUN level does not
                    if (run_rise || (run_lvl && !STOPPED)) begin
                        state     <= S_F;
                        step_mode <= 1'b0;
                        STOPPED   <= 1'b0;
                    end else if (step_rise) begin
                        state     <= S_F;
                        step_mode <= 1'b1;
                        STOPPED   <= 1'b0;
                    end
                end
                S_F: begin
                    ir      <= MEM_Q[WORD_W-1 -: 4];
                    operand <= MEM_Q[ADDR_W-1:0];
                    state   <= S_E1;
                end
                S_E1: begin
                    if (dec.EXTRA) begin
                        state <= S_E2;
                    end else begin
                        state <= end_state;
                        if (ir == STP_OP) STOPPED <= 1'b1;
                    end
                end
                S_E2: begin
                    state <= end_state;
                    if (ir == STP_OP) STOPPED <= 1'b1;
                end
                default: state <= S_HALT;
            endcase
        end
    end

    // Retired-instruction counter, wraps naturally at 2^CNT_W
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            INSTR_CNT <= '0;
        end else if (instr_end) begin
            INSTR_CNT <= INSTR_CNT + CNT_W'(1);
        end
    end

    assign HALTED      = state[0];
    assign dec.FETCH   = state[1];
    assign dec.EXEC1   = state[2];
    assign dec.EXEC2   = state[3];
    assign dec.IR      = ir;
    assign dec.OPERAND = operand;
    assign dec.EQ      = (ACC == '0);
    assign dec.MI      = ACC[DATA_W-1];
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Timing generator and instruction register for the accumulator CPU.
- Sits on the producing side of the instruction-decode interface. It drives the one-hot phase strobes FETCH/EXEC1/EXEC2 plus the IR opcode and EQ/MI flags into the decoder.
- Consumes the decoder's EXTRA request to insert a second execute cycle.
- Provides run/step/halt control and an instruction-retired counter for the board debug switches.

Parameters:
- WORD_W, 16, instruction/memory word width. Opcode = MEM_Q[WORD_W-1:WORD_W-4].
- ADDR_W, 8, operand field width. Operand = MEM_Q[ADDR_W-1:0]; requires ADDR_W <= WORD_W-4.
- DATA_W, 16, accumulator width used for flag generation.
- CNT_W, 16, instruction-retired counter width.
- STP_OP, 4'b0111, opcode that halts the sequencer.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- RUN  in  1  level. Free-run enable, synchronised internally with 2 flops.
- STEP  in  1  single-step request, raw button level. Synchronised with 2 flops, rising edge detected internally.
- MEM_Q  in  WORD_W  instruction word from program memory, valid during FETCH.
- EXTRA  in  1  from decoder: instruction needs EXEC2.
- ACC  in  DATA_W  current accumulator value.
- FETCH  out  1  phase strobe.
- EXEC1  out  1  phase strobe.
- EXEC2  out  1  phase strobe.
- IR  out  4  latched opcode.
- OPERAND  out  ADDR_W  latched operand field.
- EQ  out  1  ACC == 0.
- MI  out  1  ACC[DATA_W-1].
- HALTED  out  1  sequencer is in HALT.
- STOPPED  out  1  sticky: halt caused by STP_OP.
- INSTR_CNT  out  CNT_W  instructions retired, wraps.

Behaviour:
- Reset (async, RESET_N=0): state=HALT, HALTED=1, STOPPED=0, FETCH=EXEC1=EXEC2=0, IR=0, OPERAND=0, INSTR_CNT=0, step_mode=0, synchroniser flops=0.
- Reset asserted mid-instruction aborts immediately with no retirement count.
- States are HALT, F, E1, E2, one-hot encoded.
- Strobe outputs are registered: FETCH=1 only in F, EXEC1=1 only in E1, EXEC2=1 only in E2. Exactly one strobe or HALTED is high at all times.
- HALT:
  - sync RUN=1 and STOPPED=0 -> F, step_mode=0.
  - RUN rising edge -> clear STOPPED, then -> F, step_mode=0.
  - STEP rising edge -> clear STOPPED, then -> F, step_mode=1.
  - RUN wins if both occur in the same cycle.
  - Otherwise remain in HALT.
- F: latch IR<=MEM_Q opcode and OPERAND<=MEM_Q operand at this edge, then -> E1 unconditionally.
- E1: EXTRA=1 -> E2. Otherwise the instruction ends.
- E2: the instruction always ends.
- End of instruction, evaluated in priority order:
  - INSTR_CNT increments by 1, modulo 2^CNT_W.
  - IR==STP_OP -> HALT, STOPPED<=1.
  - else step_mode=1 or sync RUN=0 -> HALT.
  - else -> F.
- STP behaviour: with RUN held high after STP, the sequencer stays halted. A new RUN rising edge or a STEP edge is required to leave HALT.
- EXTRA is sampled only in E1 and ignored in every other state.
- STEP edges arriving while not in HALT are discarded, not queued.
- EQ and MI are combinational from ACC, so JMI/JEQ in E1 see the ACC value committed by the previous instruction's last phase.
- Latency: 2 cycles per single-phase instruction and 3 per EXTRA instruction. RUN or STEP to first FETCH takes 3 cycles (2 sync + 1 edge). The first instruction's IR/OPERAND are latched from MEM_Q at the F->E1 edge.
- The program counter is external; this block never drives memory addresses.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum (ST_HALT, ST_F, ST_E1, ST_E2);
  - opcode constants OP_LDA..OP_ASR, including OP_STP = 4'b0111;
  - default widths.
- The decoder migrates to cpu_pkg opcode constants in a follow-up.
- One sub-module: sync_edge (2-flop synchroniser plus registered rising-edge pulse), instantiated twice, for RUN and STEP.

Test Plan:
- Reset then RUN=1, MEM_Q=16'h0005 (LDA 5), EXTRA=1 in E1 -> sequence HALT,HALT,HALT,F,E1,E2,F. IR=0, OPERAND=8'h05, INSTR_CNT=1 after E2.
- RUN=1, opcode 4'b0100 (JMP), EXTRA=0 -> F,E1,F,E1 repeating. INSTR_CNT increments every 2 cycles. EXTRA forced to 1 during F has no effect.
- RUN=1, MEM_Q=16'h7000 (STP) -> after E1: HALTED=1, STOPPED=1, INSTR_CNT +1. Stays halted 20 cycles with RUN held 1. RUN 1->0->1 -> FETCH 3 cycles after the rising edge and STOPPED=0.
- RUN=0, STEP pulse -> exactly one instruction (F,E1[,E2]), then HALT. A second STEP pulse during E1 is ignored. Count rises by exactly 1 per accepted step.
- Flags: ACC=16'h0000 -> EQ=1, MI=0. ACC=16'h8001 -> EQ=0, MI=1. ACC=16'h0001 -> EQ=0, MI=0. All combinational, same cycle.
- Assert RESET_N=0 during E2, asynchronously between clock edges -> outputs return to reset values before the next edge. INSTR_CNT=0, HALTED=1. CNT_W=4 run of 17 instructions -> INSTR_CNT wraps to 1.
